// File: rtl/writeback_sequencer_pkg.sv
// wb_pkg: op_class encodings and sequencer state enum shared by the writeback sequencer files.
// Revision: 1.0
`default_nettype none
package wb_pkg;
  typedef enum logic [1:0] {
    OP_ALU  = 2'd0,
    OP_MOVE = 2'd1,
    OP_LI   = 2'd2,
    OP_MEM  = 2'd3
  } op_class_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MEM_REQ = 2'd1,
    ST_WB      = 2'd2
  } state_e;
endpackage
`default_nettype wire

// File: rtl/writeback_sequencer_if.sv
// writeback_sequencer_if: decoder, data-memory and register-file signals of the writeback sequencer.
// Revision: 1.0
`default_nettype none
interface writeback_sequencer_if #(
  parameter int REG_ADDR_W = 3
);
  logic                  instr_valid;
  logic                  instr_ready;
  logic [1:0]            op_class;
  logic                  mem_write;
  logic [REG_ADDR_W-1:0] rd;
  logic                  mem_req;
  logic                  mem_we;
  logic                  mem_ack;
  logic                  is_move;
  logic                  is_mem_access;
  logic                  is_li;
  logic                  reg_write;
  logic [REG_ADDR_W-1:0] reg_waddr;
  logic                  done;
  logic                  timeout_err;

  modport slave (
    input  instr_valid, op_class, mem_write, rd, mem_ack,
    output instr_ready, mem_req, mem_we, is_move, is_mem_access, is_li,
           reg_write, reg_waddr, done, timeout_err
  );

  modport master (
    output instr_valid, op_class, mem_write, rd, mem_ack,
    input  instr_ready, mem_req, mem_we, is_move, is_mem_access, is_li,
           reg_write, reg_waddr, done, timeout_err
  );
endinterface
`default_nettype wire

// File: rtl/writeback_sequencer_timeout.sv
// wb_timeout_counter: cycle counter with synchronous clear and terminal count at MAX-1.
// Revision: 1.0
`default_nettype none
module wb_timeout_counter #(
  parameter int MAX = 15
) (
  input  wire logic clk,
  input  wire logic reset,
  input  wire logic i_clear,
  input  wire logic i_en,
  output logic      o_tc
);
  localparam int CW = (MAX < 2) ? 1 : $clog2(MAX + 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Terminal in the MAX-th enabled cycle, so the owner leaves after exactly MAX cycles.
  assign o_tc = (r_cnt == CW'(MAX - 1));
endmodule
`default_nettype wire

// File: rtl/writeback_sequencer.sv
// writeback_sequencer: IDLE/MEM_REQ/WB control FSM for the register writeback path.
// Optional WB_MEM_TIMEOUT_EN bounds the MEM_REQ wait and raises sticky timeout_err.
`default_nettype none
module writeback_sequencer
  import wb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 15,
  parameter int REG_ADDR_W     = 3
) (
  input  wire logic              clk,
  input  wire logic              reset,
  writeback_sequencer_if.slave   bus
);
  state_e                r_state;
  state_e                w_next;
  op_class_e             r_op;
  logic                  r_we;
  logic [REG_ADDR_W-1:0] r_rd;
  logic [REG_ADDR_W-1:0] r_waddr;
  logic                  r_terr;
  logic                  w_ready;
  logic                  w_accept;
  logic                  w_timeout;
  logic                  w_is_store;

  assign w_ready  = (r_state == ST_IDLE) && !reset;
  assign w_accept = w_ready && bus.instr_valid;

`ifdef WB_MEM_TIMEOUT_EN
  logic w_tc;

  wb_timeout_counter #(
    .MAX (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (clk),
    .reset   (reset),
    .i_clear (r_state != ST_MEM_REQ),
    .i_en    (r_state == ST_MEM_REQ),
    .o_tc    (w_tc)
  );

  // A same-cycle ack takes precedence over the terminal count.
  assign w_timeout = (r_state == ST_MEM_REQ) && w_tc && !bus.mem_ack;
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_next = (op_class_e'(bus.op_class) == OP_MEM) ? ST_MEM_REQ : ST_WB;
        end
      end
      ST_MEM_REQ: begin
        if (bus.mem_ack || w_timeout) begin
          w_next = ST_WB;
        end
      end
      ST_WB:   w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_op    <= OP_ALU;
      r_we    <= 1'b0;
      r_rd    <= '0;
      r_waddr <= '0;
      r_terr  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_op   <= op_class_e'(bus.op_class);
        r_we   <= bus.mem_write;
        r_rd   <= bus.rd;
        r_terr <= 1'b0;
      end else if (w_timeout) begin
        r_terr <= 1'b1;
      end
      // Write address only moves on WB entry so it holds between writebacks.
      if ((w_next == ST_WB) && (r_state != ST_WB)) begin
        r_waddr <= w_accept ? bus.rd : r_rd;
      end
    end
  end

  assign w_is_store = (r_op == OP_MEM) && r_we;

  always_comb begin
    bus.instr_ready   = w_ready;
    bus.mem_req       = 1'b0;
    bus.mem_we        = 1'b0;
    bus.is_move       = 1'b0;
    bus.is_mem_access = 1'b0;
    bus.is_li         = 1'b0;
    bus.reg_write     = 1'b0;
    bus.done          = 1'b0;
    bus.reg_waddr     = r_waddr;
    bus.timeout_err   = r_terr;
    case (r_state)
      ST_MEM_REQ: begin
        bus.mem_req = 1'b1;
        bus.mem_we  = r_we;
      end
      ST_WB: begin
        bus.done          = 1'b1;
        bus.is_move       = (r_op == OP_MOVE);
        bus.is_li         = (r_op == OP_LI);
        bus.is_mem_access = (r_op == OP_MEM) && !r_we;
        // r_terr is set only on the MEM_REQ->WB timeout edge of this very operation.
        bus.reg_write     = !w_is_store && (r_rd != '0) && !r_terr;
      end
      default: begin
      end
    endcase
  end
endmodule
`default_nettype wire

// File: tb/tb_writeback_sequencer.sv
// tb_writeback_sequencer: table-driven directed vectors plus reset and timeout sequences.
`default_nettype none
module tb_writeback_sequencer;
  logic clk;
  logic reset;
  int   n_pass;
  int   n_total;

  writeback_sequencer_if #(.REG_ADDR_W(3)) bus ();

  writeback_sequencer #(
    .TIMEOUT_CYCLES (4),
    .REG_ADDR_W     (3)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [1:0] op;
    logic       mw;
    logic [2:0] rd;
    int         lat;
    logic       mv;
    logic       ma;
    logic       li;
    logic       rw;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string nm, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
  endtask

  task automatic chk_idle_outs(input string nm);
    chk({nm, "_done"}, bus.done, 0);
    chk({nm, "_reg_write"}, bus.reg_write, 0);
    chk({nm, "_selects"}, {bus.is_move, bus.is_mem_access, bus.is_li}, 0);
  endtask

  // Called at a negedge with the sequencer idle; returns at the negedge after WB.
  task automatic run_vec(input int i);
    vec_t v;
    int   cnt;
    v = vecs[i];
    chk($sformatf("v%0d_ready", i), bus.instr_ready, 1);
    bus.instr_valid = 1'b1;
    bus.op_class    = v.op;
    bus.mem_write   = v.mw;
    bus.rd          = v.rd;
    @(negedge clk);
    bus.instr_valid = 1'b0;
    bus.rd          = ~v.rd;
    bus.mem_write   = ~v.mw;
    cnt = 0;
    if (v.op == 2'd3) begin
      while (bus.mem_req === 1'b1 && cnt < 40) begin
        chk($sformatf("v%0d_mem_we", i), bus.mem_we, v.mw);
        chk($sformatf("v%0d_ready_busy", i), bus.instr_ready, 0);
        cnt++;
        if (cnt == v.lat) bus.mem_ack = 1'b1;
        @(negedge clk);
        bus.mem_ack = 1'b0;
      end
      chk($sformatf("v%0d_req_cycles", i), cnt, v.lat);
    end else begin
      chk($sformatf("v%0d_no_req", i), bus.mem_req, 0);
    end
    chk($sformatf("v%0d_done", i), bus.done, 1);
    chk($sformatf("v%0d_is_move", i), bus.is_move, v.mv);
    chk($sformatf("v%0d_is_mem", i), bus.is_mem_access, v.ma);
    chk($sformatf("v%0d_is_li", i), bus.is_li, v.li);
    chk($sformatf("v%0d_reg_write", i), bus.reg_write, v.rw);
    chk($sformatf("v%0d_waddr", i), bus.reg_waddr, v.rd);
    chk($sformatf("v%0d_terr", i), bus.timeout_err, 0);
    chk($sformatf("v%0d_wb_req", i), bus.mem_req, 0);
    @(negedge clk);
    chk_idle_outs($sformatf("v%0d_post", i));
    chk($sformatf("v%0d_post_ready", i), bus.instr_ready, 1);
    chk($sformatf("v%0d_waddr_hold", i), bus.reg_waddr, v.rd);
  endtask

  initial begin
    int cnt;
    n_pass  = 0;
    n_total = 0;
    //            op    mw    rd    lat mv ma li rw
    vecs[0]  = '{2'd0, 1'b0, 3'd5, 0, 0, 0, 0, 1}; // ALU rd5
    vecs[1]  = '{2'd2, 1'b0, 3'd2, 0, 0, 0, 1, 1}; // LI rd2
    vecs[2]  = '{2'd1, 1'b0, 3'd3, 0, 1, 0, 0, 1}; // MOVE rd3 right after LI
    vecs[3]  = '{2'd3, 1'b0, 3'd4, 3, 0, 1, 0, 1}; // load, ack on 3rd req cycle
    vecs[4]  = '{2'd3, 1'b1, 3'd4, 3, 0, 0, 0, 0}; // store, same timing
    vecs[5]  = '{2'd0, 1'b0, 3'd0, 0, 0, 0, 0, 0}; // ALU rd0: no write
    vecs[6]  = '{2'd3, 1'b0, 3'd6, 1, 0, 1, 0, 1}; // load, ack in first req cycle
    vecs[7]  = '{2'd1, 1'b1, 3'd7, 0, 1, 0, 0, 1}; // MOVE, mem_write ignored
    vecs[8]  = '{2'd2, 1'b0, 3'd0, 0, 0, 0, 1, 0}; // LI rd0
    vecs[9]  = '{2'd3, 1'b1, 3'd0, 2, 0, 0, 0, 0}; // store rd0
    vecs[10] = '{2'd3, 1'b0, 3'd1, 4, 0, 1, 0, 1}; // load, ack on 4th cycle
    reset = 1'b1;
    bus.instr_valid = 1'b0;
    bus.op_class    = 2'd0;
    bus.mem_write   = 1'b0;
    bus.rd          = 3'd0;
    bus.mem_ack     = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ready", bus.instr_ready, 0);
    chk("rst_mem_req", bus.mem_req, 0);
    chk("rst_mem_we", bus.mem_we, 0);
    chk("rst_waddr", bus.reg_waddr, 0);
    chk("rst_terr", bus.timeout_err, 0);
    chk_idle_outs("rst");
    reset = 1'b0;
    #1;
    chk("first_ready", bus.instr_ready, 1);

    for (int i = 0; i < 11; i++) run_vec(i);

    // Ack while idle must be ignored.
    bus.mem_ack = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("idle_ack_req", bus.mem_req, 0);
      chk_idle_outs("idle_ack");
    end
    bus.mem_ack = 1'b0;

    // Asynchronous reset in the middle of a MEM_REQ.
    bus.instr_valid = 1'b1;
    bus.op_class    = 2'd3;
    bus.mem_write   = 1'b0;
    bus.rd          = 3'd6;
    @(negedge clk);
    bus.instr_valid = 1'b0;
    chk("mid_req_up", bus.mem_req, 1);
    #2 reset = 1'b1;
    #1;
    chk("mid_req_drop", bus.mem_req, 0);
    chk("mid_ready_low", bus.instr_ready, 0);
    chk_idle_outs("mid_rst");
    @(negedge clk);
    reset = 1'b0;
    bus.mem_ack = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("post_rst_req", bus.mem_req, 0);
      chk_idle_outs("post_rst");
      chk("post_rst_waddr", bus.reg_waddr, 0);
    end
    bus.mem_ack = 1'b0;

`ifdef WB_MEM_TIMEOUT_EN
    bus.instr_valid = 1'b1;
    bus.op_class    = 2'd3;
    bus.mem_write   = 1'b0;
    bus.rd          = 3'd4;
    @(negedge clk);
    bus.instr_valid = 1'b0;
    cnt = 0;
    while (bus.mem_req === 1'b1 && cnt < 40) begin
      cnt++;
      @(negedge clk);
    end
    chk("to_req_cycles", cnt, 4);
    chk("to_done", bus.done, 1);
    chk("to_reg_write", bus.reg_write, 0);
    chk("to_terr", bus.timeout_err, 1);
    @(negedge clk);
    chk("to_terr_sticky", bus.timeout_err, 1);
    chk("to_post_done", bus.done, 0);
    bus.instr_valid = 1'b1;
    bus.op_class    = 2'd0;
    bus.rd          = 3'd1;
    @(negedge clk);
    bus.instr_valid = 1'b0;
    chk("to_clear_terr", bus.timeout_err, 0);
    chk("to_next_write", bus.reg_write, 1);
    chk("to_next_done", bus.done, 1);
    @(negedge clk);
`else
    cnt = 0;
    chk("no_macro_terr", bus.timeout_err + cnt, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/writeback_sequencer.md
# writeback_sequencer

Multi-cycle control FSM that sequences the 8-bit processor's register writeback path. It accepts one decoded instruction at a time and runs the data-memory handshake for loads and stores. It then drives the three select lines of the writeback data mux (`is_move`, `is_mem_access`, `is_li`) together with the register-file write enable and address. It sits between the decoder and the register file, owning all writeback timing.

## Interface
- `TIMEOUT_CYCLES`, 15: cycles `MEM_REQ` may wait for `mem_ack` (only with `WB_MEM_TIMEOUT_EN`).
- `REG_ADDR_W`, 3: register address width.
- Clock and reset: one clock, `clk`; reset `reset` is asynchronous and active-high.
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous active-high reset.
- `instr_valid`  in  1  decoded instruction present.
- `instr_ready`  out  1  sequencer can accept.
- `op_class`  in  2  0=ALU, 1=MOVE, 2=LI, 3=MEM.
- `mem_write`  in  1  for MEM: 1=store, 0=load; ignored otherwise.
- `rd`  in  REG_ADDR_W  destination register.
- `mem_req`  out  1  data-memory request, held until ack.
- `mem_we`  out  1  store qualifier, valid while `mem_req`=1.
- `mem_ack`  in  1  memory completion.
- `is_move`, `is_mem_access`, `is_li`  out  1 each  writeback mux selects.
- `reg_write`  out  1  register-file write enable.
- `reg_waddr`  out  REG_ADDR_W  write address.
- `done`  out  1  one-cycle completion pulse.
- `timeout_err`  out  1  sticky timeout flag (macro-gated).

## Operation
- States: `IDLE`, `MEM_REQ`, `WB`.
- `IDLE`: `instr_ready`=1. An accept occurs when `instr_valid`&`instr_ready`. On accept, latch `op_class`, `mem_write` and `rd`.
  - MEM goes to `MEM_REQ`.
  - All other classes go to `WB`.
- `MEM_REQ`: `mem_req`=1, `mem_we`=latched `mem_write`. When `mem_ack`=1 is sampled, go to `WB`. Ack in the first `MEM_REQ` cycle is legal.
- `WB` (exactly one cycle): `done`=1.
  - Selects decode from the latched class: MOVE sets `is_move`, LI sets `is_li`, load sets `is_mem_access`. ALU leaves all three at 0.
  - At most one select is ever high.
  - `reg_write`=1 except for stores or latched `rd`==0.
  - `reg_waddr`=latched `rd`.
  - Next state is `IDLE`.
- Outside `WB`: all selects, `reg_write` and `done` are 0; `reg_waddr` holds its last value.
- `mem_ack` outside `MEM_REQ` is ignored.
- `instr_valid` while not ready is ignored. The decoder must hold the instruction.

## Timing
- Reset values: state `IDLE`; `mem_req`, `mem_we`, selects, `reg_write`, `done`, `timeout_err` all 0; `reg_waddr` 0.
- `instr_ready` is 0 while `reset` is high.
- Reset mid-operation: `mem_req` drops immediately (asynchronous). No writeback and no `done` are produced.
- ALU/MOVE/LI: accept in cycle N, writeback in N+1, next accept possible in N+2.
- MEM: accept in N, `mem_req` high from N+1. If ack arrives in cycle M, `WB` occurs in M+1.
- All outputs are registered-state decodes: Moore outputs only, no combinational path from inputs to outputs.

## Configuration
- `WB_MEM_TIMEOUT_EN` defined:
  - A counter runs in `MEM_REQ`, cleared on entry.
  - If `TIMEOUT_CYCLES` cycles pass with no ack, drop `mem_req`, go to `WB` with `reg_write` forced 0, and pulse `done`.
  - Set `timeout_err`. It stays high until the next accept or reset.
  - If ack arrives in the same cycle the count is reached, ack wins.
- Undefined: no counter; `MEM_REQ` waits indefinitely; `timeout_err` is tied to 0.

## Structure
- Package `wb_pkg`: `op_class` encodings (`OP_ALU`, `OP_MOVE`, `OP_LI`, `OP_MEM`) and the state enum.
- Sub-module `wb_timeout_counter` (clear, enable, terminal-count output), instantiated only under `WB_MEM_TIMEOUT_EN`.

## Test plan
- After reset: all outputs 0. First cycle after release: `instr_ready`=1.
- ALU, rd=5, accepted cycle 2: cycle 3 has `reg_write`=1, `reg_waddr`=5, all selects 0, `done`=1. Cycle 4 has `instr_ready`=1.
- LI rd=2, then MOVE rd=3 back-to-back: `is_li` pulses in the first `WB`, `is_move` in the second, never overlapping.
- Load rd=4 with ack 3 cycles after request: `mem_req` held 3 cycles, then `WB` with `is_mem_access`=1 and `reg_write`=1. A store under the same stimulus gives `reg_write`=0 and `done`=1.
- rd=0 ALU: `done`=1 with `reg_write`=0. Reset asserted mid-`MEM_REQ`: `mem_req` drops in the same cycle and no `done` occurs.
- With macro and `TIMEOUT_CYCLES`=4, no ack: `mem_req` drops after 4 cycles, `done`=1, `timeout_err`=1, `reg_write`=0. A subsequent accept clears `timeout_err`.
